aes_output_fifo: RTL and testbench

//  Downstream stage of aes_cipher_top. Captures each 128-bit ciphertext block on the

---
 rtl/aes_pkg.sv | 7 +
 rtl/aes_fifo_ram.sv | 25 ++
 rtl/aes_output_fifo.sv | 77 +++++++
 tb/tb_aes_output_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath types.
//   AES_BLK_W   : cipher block width in bits
//   aes_block_t : one 128-bit cipher block
package aes_pkg;
  localparam int AES_BLK_W = 128;
  typedef logic [AES_BLK_W-1:0] aes_block_t;
endpackage

// File: rtl/aes_fifo_ram.sv
// DEPTH x DATA_W register array for the output queue.
//   clk            : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : asynchronous read port (feeds first-word-fall-through output)
// Storage is deliberately not reset.
module aes_fifo_ram #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/aes_output_fifo.sv
// Output queue behind aes_cipher_top.
//   done_i/text_i : cipher done (rising edge = push) and its ciphertext
//   out_valid/out_ready/text_o : first-word-fall-through consumer handshake
//   count/full/space_ok : occupancy; space_ok tells aes_input_buffer an ld may issue
//   overflow/clr_ovf    : sticky dropped-block flag and its synchronous clear
// All status outputs decode from the registered count, so out_ready has no
// combinational path to any output.
module aes_output_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = AES_BLK_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done_i,
  input  logic [DATA_W-1:0]          text_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          text_o,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       space_ok,
  output logic                       overflow,
  input  logic                       clr_ovf
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              done_q;
  logic [DATA_W-1:0] rdata;
  logic              push, pop, wr_en, drop;

  assign push  = done_i & ~done_q;
  assign pop   = out_valid & out_ready;
  // A pop frees the head slot this cycle, so a push while full still fits.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  assign out_valid = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign space_ok  = (count <= CNT_W'(DEPTH-2));
  // Zero when empty so the output is clean after reset without clearing storage.
  assign text_o    = out_valid ? rdata : '0;

  aes_fifo_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (text_i),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      done_q <= done_i;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A new drop wins over a same-cycle clear.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_aes_output_fifo.sv
module tb_aes_output_fifo;
  localparam int DEPTH = 4;
  localparam int DW    = 128;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0, rst = 1'b0;
  logic          done_i = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
  logic [DW-1:0] text_i = '0;
  logic          out_valid, full, space_ok, overflow;
  logic [DW-1:0] text_o;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;

  aes_output_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .text_i(text_i),
    .out_valid(out_valid), .out_ready(out_ready), .text_o(text_o),
    .count(count), .full(full), .space_ok(space_ok),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          done;
    logic [DW-1:0] txt;
    logic          rdy;
    logic          clr;
    logic          e_vld;
    logic [CW-1:0] e_cnt;
    logic          e_full;
    logic          e_space;
    logic          e_ovf;
    logic [DW-1:0] e_txt;
  } vec_t;

  vec_t tbl[14];

  // reference model state
  logic [DW-1:0] mq[$];
  bit            m_ovf, m_prev;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // status = {out_valid, count, full, space_ok, overflow}
  task automatic chk_stat(input string nm, input logic v, input logic [CW-1:0] c,
                          input logic f, input logic s, input logic o);
    chk(nm, DW'({out_valid, count, full, space_ok, overflow}), DW'({v, c, f, s, o}));
  endtask

  task automatic push(input logic [DW-1:0] v);
    done_i = 1'b1; text_i = v; step();
    done_i = 1'b0; step();
  endtask

  function automatic vec_t mk(input logic d, input logic [DW-1:0] t, input logic r,
                              input logic c, input logic v, input int n,
                              input logic o, input logic [DW-1:0] et);
    vec_t x;
    x.done = d; x.txt = t; x.rdy = r; x.clr = c;
    x.e_vld = v; x.e_cnt = CW'(n); x.e_full = (n == DEPTH);
    x.e_space = (n <= DEPTH-2); x.e_ovf = o; x.e_txt = et;
    return x;
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model step from the rules: pop head first, then accept push if there is room.
  task automatic model_step(input logic d, input logic [DW-1:0] t, input logic r,
                            input logic c);
    bit p, drop;
    p    = d && !m_prev;
    drop = 1'b0;
    if (mq.size() != 0 && r) void'(mq.pop_front());
    if (p) begin
      if (mq.size() < DEPTH) mq.push_back(t);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    m_prev = d;
  endtask

  logic [DW-1:0] A, B, C, D, E, F, T0;
  logic [DW-1:0] hv[4];

  initial begin
    A = 128'hA0; B = 128'hB1; C = 128'hC2; D = 128'hD3; E = 128'hE4; F = 128'hF5;
    T0 = 128'h3925841d02dc09fbdc118597196a0b32;

    // Fill / overflow / drain / clear, one row per cycle.
    tbl[0]  = mk(1, A, 0, 0, 1, 1, 0, A);
    tbl[1]  = mk(0, 0, 0, 0, 1, 1, 0, A);
    tbl[2]  = mk(1, B, 0, 0, 1, 2, 0, A);
    tbl[3]  = mk(0, 0, 0, 0, 1, 2, 0, A);
    tbl[4]  = mk(1, C, 0, 0, 1, 3, 0, A);
    tbl[5]  = mk(0, 0, 0, 0, 1, 3, 0, A);
    tbl[6]  = mk(1, D, 0, 0, 1, 4, 0, A);
    tbl[7]  = mk(0, 0, 0, 0, 1, 4, 0, A);
    tbl[8]  = mk(1, E, 0, 0, 1, 4, 1, A);
    tbl[9]  = mk(0, 0, 1, 0, 1, 3, 1, B);
    tbl[10] = mk(0, 0, 1, 0, 1, 2, 1, C);
    tbl[11] = mk(0, 0, 1, 0, 1, 1, 1, D);
    tbl[12] = mk(0, 0, 1, 0, 0, 0, 1, 0);
    tbl[13] = mk(0, 0, 0, 1, 0, 0, 0, 0);

    // 1. reset and idle
    #2;
    chk_stat("reset_in", 0, 0, 0, 1, 0);
    chk("reset_text", text_o, '0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    step(); step();
    chk_stat("idle", 0, 0, 0, 1, 0);

    // 2. single block, hold, pop
    done_i = 1'b1; text_i = T0; step();
    done_i = 1'b0; text_i = '0;
    chk_stat("single_vld", 1, 1, 0, 1, 0);
    chk("single_text", text_o, T0);
    for (int i = 0; i < 5; i++) step();
    chk("single_hold", DW'({out_valid, count}), DW'({1'b1, CW'(1)}));
    chk("single_hold_text", text_o, T0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk_stat("single_pop", 0, 0, 0, 1, 0);

    // 3. done held 4 cycles -> one push, first text only
    done_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      text_i = 128'h1000 + DW'(i);
      step();
    end
    done_i = 1'b0;
    chk_stat("held_cnt", 1, 1, 0, 1, 0);
    chk("held_text", text_o, 128'h1000);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk_stat("held_empty", 0, 0, 0, 1, 0);

    // 4. table
    foreach (tbl[i]) begin
      done_i = tbl[i].done; text_i = tbl[i].txt;
      out_ready = tbl[i].rdy; clr_ovf = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_stat", i),
          DW'({out_valid, count, full, space_ok, overflow}),
          DW'({tbl[i].e_vld, tbl[i].e_cnt, tbl[i].e_full, tbl[i].e_space, tbl[i].e_ovf}));
      chk($sformatf("tbl%0d_text", i), text_o, tbl[i].e_txt);
    end
    done_i = 0; out_ready = 0; clr_ovf = 0; text_i = '0;

    // 5. full, push + pop same cycle (wraps wr_ptr)
    for (int i = 0; i < 4; i++) begin
      hv[i] = 128'h5500 + DW'(i);
      push(hv[i]);
    end
    chk_stat("wrap_full", 1, 4, 1, 0, 0);
    done_i = 1'b1; text_i = 128'h55AA; out_ready = 1'b1; step();
    done_i = 1'b0; out_ready = 1'b0;
    chk_stat("wrap_pushpop", 1, 4, 1, 0, 0);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("wrap_out%0d", i), text_o, hv[i]);
      out_ready = 1'b1; step(); out_ready = 1'b0;
    end
    chk("wrap_new", text_o, 128'h55AA);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk_stat("wrap_empty", 0, 0, 0, 1, 0);

    // 6. async reset mid-stream
    push(A); push(B); push(C);
    chk_stat("pre_rst", 1, 3, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk_stat("async_rst", 0, 0, 0, 1, 0);
    chk("async_rst_text", text_o, '0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    push(F);
    chk("post_rst_first", text_o, F);
    chk_stat("post_rst_stat", 1, 1, 0, 1, 0);

    // 7. randomized run against the queue model
    rst = 1'b0; #1; @(negedge clk); rst = 1'b1;
    mq.delete(); m_ovf = 0; m_prev = 0;
    for (int n = 0; n < 2000; n++) begin
      logic d, r, c;
      logic [DW-1:0] t;
      d = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 40);
      c = ($urandom_range(0, 99) < 8);
      t = rnd128();
      done_i = d; out_ready = r; clr_ovf = c; text_i = t;
      model_step(d, t, r, c);
      step();
      chk($sformatf("rnd%0d_stat", n),
          DW'({out_valid, count, full, space_ok, overflow}),
          DW'({mq.size() != 0, CW'(mq.size()), mq.size() == DEPTH,
               mq.size() <= DEPTH-2, m_ovf}));
      chk($sformatf("rnd%0d_text", n), text_o, (mq.size() != 0) ? mq[0] : '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
